// File: rtl/alu_pkg.sv
// Shared types for the multi-word ALU sequencer and the 64-bit ALU it drives.
package alu_pkg;

    localparam int WORD_W = 64;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t OP_ADD = 2'd0;
    localparam alu_op_t OP_SUB = 2'd1;
    localparam alu_op_t OP_AND = 2'd2;
    localparam alu_op_t OP_XOR = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_mw_seq_if.sv
// Request/response handshake bus for one NWORDS*64-bit ALU operation.
interface alu_mw_seq_if #(
    parameter int NWORDS = 4
);
    import alu_pkg::*;

    localparam int WIDTH = WORD_W * NWORDS;

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_cin;
    alu_op_t          req_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_s;
    logic             rsp_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_s, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_s, rsp_cout
    );

endinterface

// File: rtl/alu64bit.sv
// Purely combinational 64-bit ALU: ADD, SUB (a + ~b + cin), AND, XOR.
module alu64bit
    import alu_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    input  alu_op_t           op,
    output logic [WORD_W-1:0] s,
    output logic              cout
);

    logic [WORD_W:0] sum;

    // Logic ops report cout=0; the sequencer forwards whatever comes out.
    always_comb begin
        sum = '0;
        case (op)
            OP_ADD:  sum = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
            OP_SUB:  sum = {1'b0, a} + {1'b0, ~b} + {{WORD_W{1'b0}}, cin};
            OP_AND:  sum = {1'b0, a & b};
            default: sum = {1'b0, a ^ b};
        endcase
        s    = sum[WORD_W-1:0];
        cout = sum[WORD_W];
    end

endmodule

// File: rtl/alu_mw_top.sv
// Integration wrapper: multi-word sequencer beside the 64-bit combinational ALU.
module alu_mw_top
    import alu_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_mw_seq_if.slave bus
);

    logic [WORD_W-1:0] alu_a;
    logic [WORD_W-1:0] alu_b;
    logic              alu_cin;
    alu_op_t           alu_op;
    logic [WORD_W-1:0] alu_s;
    logic              alu_cout;

    alu_mw_seq #(.NWORDS(NWORDS)) u_seq (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_op   (alu_op),
        .alu_s    (alu_s),
        .alu_cout (alu_cout)
    );

    alu64bit u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .cin  (alu_cin),
        .op   (alu_op),
        .s    (alu_s),
        .cout (alu_cout)
    );

endmodule

// File: rtl/alu_mw_seq.sv
// Multi-word sequencer: feeds a combinational 64-bit ALU one word per cycle, LSW first,
// chaining carry through a register and assembling the full-width result.
module alu_mw_seq
    import alu_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_mw_seq_if.slave       bus,
    output logic [WORD_W-1:0] alu_a,
    output logic [WORD_W-1:0] alu_b,
    output logic              alu_cin,
    output alu_op_t           alu_op,
    input  logic [WORD_W-1:0] alu_s,
    input  logic              alu_cout
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef logic [NWORDS-1:0][WORD_W-1:0] words_t;

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    alu_op_t          op_q, op_d;
    words_t           a_q, a_d;
    words_t           b_q, b_d;
    words_t           res_q, res_d;

    logic accept;
    logic last;

    assign accept = (state_q == IDLE) && bus.req_valid;
    assign last   = (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = RUN;
            RUN:     if (last)          state_d = DONE;
            DONE:    if (bus.rsp_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Datapath next values: operand latch on accept, word capture while running
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        if (accept) begin
            a_d     = bus.req_a;
            b_d     = bus.req_b;
            op_d    = bus.req_op;
            carry_d = bus.req_cin;
            idx_d   = '0;
        end else if (state_q == RUN) begin
            res_d[idx_q] = alu_s;
            carry_d      = alu_cout;
            idx_d        = last ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Outputs: ALU bus only live in RUN, response only live in DONE
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = (state_q == DONE);
        bus.rsp_s     = '0;
        bus.rsp_cout  = 1'b0;
        alu_a         = '0;
        alu_b         = '0;
        alu_cin       = 1'b0;
        alu_op        = '0;
        if (state_q == RUN) begin
            alu_a   = a_q[idx_q];
            alu_b   = b_q[idx_q];
            alu_cin = carry_q;
            alu_op  = op_q;
        end
        if (state_q == DONE) begin
            bus.rsp_s    = res_q;
            bus.rsp_cout = carry_q;
        end
    end

endmodule

// File: tb/tb_alu_mw_seq.sv
// Directed bench for the multi-word sequencer with the real 64-bit ALU (NWORDS=4 and NWORDS=1).
module tb_alu_mw_seq;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    alu_mw_seq_if #(.NWORDS(4)) bus4 ();
    alu_mw_seq_if #(.NWORDS(1)) bus1 ();

    logic [WORD_W-1:0] alu1_a;
    logic [WORD_W-1:0] alu1_b;
    logic              alu1_cin;
    alu_op_t           alu1_op;
    logic [WORD_W-1:0] alu1_s;
    logic              alu1_cout;

    alu_mw_top #(.NWORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    alu_mw_seq #(.NWORDS(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus1),
        .alu_a    (alu1_a),
        .alu_b    (alu1_b),
        .alu_cin  (alu1_cin),
        .alu_op   (alu1_op),
        .alu_s    (alu1_s),
        .alu_cout (alu1_cout)
    );

    alu64bit u_alu1 (
        .a    (alu1_a),
        .b    (alu1_b),
        .cin  (alu1_cin),
        .op   (alu1_op),
        .s    (alu1_s),
        .cout (alu1_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full NWORDS=4 transaction, optionally holding rsp_ready low for 'hold' cycles.
    task automatic run4(input string tag, input logic [255:0] a, input logic [255:0] b,
                        input logic cin, input alu_op_t op,
                        input logic [255:0] es, input logic ec, input int hold);
        int lat;
        chk({tag, ":req_ready"}, bus4.req_ready, 1'b1);
        bus4.req_valid = 1'b1;
        bus4.req_a     = a;
        bus4.req_b     = b;
        bus4.req_cin   = cin;
        bus4.req_op    = op;
        tick();
        bus4.req_valid = 1'b0;
        chk({tag, ":alu_a0"}, dut4.alu_a, a[63:0]);
        chk({tag, ":alu_cin0"}, dut4.alu_cin, cin);
        chk({tag, ":alu_op"}, dut4.alu_op, op);
        lat = 0;
        while (!bus4.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, ":latency"}, lat, 4);
        chk({tag, ":rsp_s"}, bus4.rsp_s, es);
        chk({tag, ":rsp_cout"}, bus4.rsp_cout, ec);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk({tag, ":hold_valid"}, bus4.rsp_valid, 1'b1);
            chk({tag, ":hold_s"}, bus4.rsp_s, es);
            chk({tag, ":hold_cout"}, bus4.rsp_cout, ec);
            chk({tag, ":hold_req_ready"}, bus4.req_ready, 1'b0);
        end
        bus4.rsp_ready = 1'b1;
        tick();
        bus4.rsp_ready = 1'b0;
        chk({tag, ":rsp_valid_drop"}, bus4.rsp_valid, 1'b0);
        chk({tag, ":req_ready_back"}, bus4.req_ready, 1'b1);
    endtask

    initial begin
        int lat;
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        bus4.req_valid = 1'b0; bus4.req_a = '0; bus4.req_b = '0;
        bus4.req_cin = 1'b0;   bus4.req_op = OP_ADD; bus4.rsp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_a = '0; bus1.req_b = '0;
        bus1.req_cin = 1'b0;   bus1.req_op = OP_ADD; bus1.rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst:req_ready", bus4.req_ready, 1'b1);
        chk("rst:rsp_valid", bus4.rsp_valid, 1'b0);
        chk("rst:rsp_s", bus4.rsp_s, '0);
        chk("rst:rsp_cout", bus4.rsp_cout, 1'b0);
        chk("rst:alu_a", dut4.alu_a, '0);
        chk("rst:alu_b", dut4.alu_b, '0);
        chk("rst:alu_cin", dut4.alu_cin, 1'b0);
        chk("rst:alu_op", dut4.alu_op, '0);

        // Carry ripples through every word
        run4("ripple", {256{1'b1}}, 256'd1, 1'b0, OP_ADD, 256'd0, 1'b1, 0);

        // No carry between words
        run4("nocarry", {128'd0, 64'h3, 64'h1}, {128'd0, 64'h1, 64'h2}, 1'b0, OP_ADD,
             {128'd0, 64'h4, 64'h3}, 1'b0, 0);

        // 0 - 1 via SUB with cin=1: all ones, no carry out
        run4("sub", 256'd0, 256'd1, 1'b1, OP_SUB, {256{1'b1}}, 1'b0, 0);

        // Backpressure: 5 cycles with rsp_ready low
        run4("bp", {64'h8000_0000_0000_0000, 192'd5}, {64'h8000_0000_0000_0000, 192'd7},
             1'b0, OP_ADD, 256'd12, 1'b1, 5);

        // Busy drop: second request held during RUN/DONE must wait for IDLE
        bus4.req_valid = 1'b1;
        bus4.req_a = 256'd100; bus4.req_b = 256'd23; bus4.req_cin = 1'b0; bus4.req_op = OP_ADD;
        tick();
        bus4.req_a = {128'd0, 64'h1, 64'h0}; bus4.req_b = 256'd5;
        for (int k = 0; k < 4; k++) begin
            chk("busy:req_ready", bus4.req_ready, 1'b0);
            tick();
        end
        chk("busy:rsp_valid1", bus4.rsp_valid, 1'b1);
        chk("busy:rsp_s1", bus4.rsp_s, 256'd123);
        bus4.rsp_ready = 1'b1;
        tick();
        bus4.rsp_ready = 1'b0;
        chk("busy:idle_ready", bus4.req_ready, 1'b1);
        tick();
        bus4.req_valid = 1'b0;
        chk("busy:alu_a2", dut4.alu_a, 64'h0);
        lat = 0;
        while (!bus4.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("busy:latency2", lat, 4);
        chk("busy:rsp_s2", bus4.rsp_s, {128'd0, 64'h1, 64'h5});
        bus4.rsp_ready = 1'b1;
        tick();
        bus4.rsp_ready = 1'b0;

        // Reset while idx == 2
        bus4.req_valid = 1'b1;
        bus4.req_a = {256{1'b1}}; bus4.req_b = 256'd1; bus4.req_cin = 1'b0; bus4.req_op = OP_SUB;
        tick();
        bus4.req_valid = 1'b0;
        tick();
        tick();
        chk("midrst:alu_b_word2", dut4.alu_b, 64'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst:req_ready", bus4.req_ready, 1'b1);
        chk("midrst:rsp_valid", bus4.rsp_valid, 1'b0);
        chk("midrst:alu_a", dut4.alu_a, '0);
        chk("midrst:alu_b", dut4.alu_b, '0);
        chk("midrst:alu_cin", dut4.alu_cin, 1'b0);
        chk("midrst:alu_op", dut4.alu_op, '0);
        for (int k = 0; k < 6; k++) tick();
        chk("midrst:no_rsp", bus4.rsp_valid, 1'b0);
        run4("post_rst", {64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF},
             {64'h0, 64'h0, 64'h0, 64'h1}, 1'b0, OP_ADD,
             {64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0}, 1'b0, 0);

        // NWORDS=1: single RUN cycle
        chk("n1:req_ready", bus1.req_ready, 1'b1);
        bus1.req_valid = 1'b1;
        bus1.req_a = 64'hFFFF_FFFF_FFFF_FFFF; bus1.req_b = 64'd1;
        bus1.req_cin = 1'b0; bus1.req_op = OP_ADD;
        tick();
        bus1.req_valid = 1'b0;
        chk("n1:alu_a", dut1.alu_a, 64'hFFFF_FFFF_FFFF_FFFF);
        lat = 0;
        while (!bus1.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("n1:latency", lat, 1);
        chk("n1:rsp_s", bus1.rsp_s, 64'd0);
        chk("n1:rsp_cout", bus1.rsp_cout, 1'b1);
        bus1.rsp_ready = 1'b1;
        tick();
        bus1.rsp_ready = 1'b0;
        chk("n1:req_ready_back", bus1.req_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
